// File: rtl/audio_pkg.sv
// Shared constants and capture-state encoding for the serial audio link.
package audio_pkg;

   localparam int CLK_DIV_HALF = 71;
   localparam int WORD_W       = 16;
   localparam int DEPTH        = 176400;
   localparam int ADDR_W       = 18;
   localparam int ADDR_BASE    = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_t;

endpackage

// File: rtl/audio_bit_clock_gen.sv
// Bit-clock generator: free-running half-period divider, BIT_CLK toggle,
// and one-cycle strobes marking the cycle just before each BIT_CLK edge.
module audio_bit_clock_gen
   import audio_pkg::*;
#(
   parameter int DIV_HALF = CLK_DIV_HALF
) (
   input  logic i_clk,
   input  logic i_clr_n,
   output logic o_bit_clk,
   output logic o_rise_tick,
   output logic o_fall_tick
);

   localparam int CNT_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_HALF - 1);

   logic [CNT_W-1:0] r_count;
   logic             r_bit_clk;
   logic             w_term;

   assign w_term = (r_count == CNT_LAST);

   // Count 0..DIV_HALF-1, toggle the bit clock at terminal count.
   always_ff @(posedge i_clk) begin
      if (!i_clr_n) begin
         r_count   <= '0;
         r_bit_clk <= 1'b0;
      end else if (w_term) begin
         r_count   <= '0;
         r_bit_clk <= ~r_bit_clk;
      end else begin
         r_count   <= r_count + 1'b1;
      end
   end

   assign o_bit_clk   = r_bit_clk;
   assign o_rise_tick = w_term & ~r_bit_clk;
   assign o_fall_tick = w_term &  r_bit_clk;

endmodule

// File: rtl/audio_serial_capture.sv
// Serial audio receive path: shifts in MSB-first words on the bit-clock
// rising-edge tick and streams them to an external sample RAM.
//
//  state      | meaning
//  -----------+---------------------------------------------------------
//  ST_IDLE    | out of reset or after Abort; waiting for Start
//  ST_ARM     | Start seen; next capture tick takes the MSB
//  ST_CAPTURE | shifting bits, one write per completed word
//  ST_DONE    | DEPTH samples written; Done held until next Start
module audio_serial_capture
   import audio_pkg::*;
#(
   parameter int P_CLK_DIV_HALF = CLK_DIV_HALF,
   parameter int P_WORD_W       = WORD_W,
   parameter int DEPTH          = audio_pkg::DEPTH,
   parameter int P_ADDR_W       = ADDR_W,
   parameter int P_ADDR_BASE    = ADDR_BASE
) (
   input  logic                Clock_100MHz,
   input  logic                Clear_n,
   input  logic                Start,
   input  logic                Abort,
   input  logic                AUD_DATA_IN,
   output logic                BIT_CLK,
   output logic [P_WORD_W-1:0] Sample_Data,
   output logic                Sample_Valid,
   output logic                Wr_En,
   output logic [P_ADDR_W-1:0] Wr_Addr,
   output logic [P_WORD_W-1:0] Wr_Data,
   output logic                Busy,
   output logic                Done
);

   localparam int BCNT_W = (P_WORD_W > 1) ? $clog2(P_WORD_W) : 1;
   localparam logic [BCNT_W-1:0]   BCNT_TOP  = BCNT_W'(P_WORD_W - 1);
   localparam logic [P_ADDR_W-1:0] ADDR_FRST = P_ADDR_W'(P_ADDR_BASE);
   localparam logic [P_ADDR_W-1:0] ADDR_LAST = P_ADDR_W'(P_ADDR_BASE + DEPTH - 1);

   cap_state_t          r_state;
   logic [P_WORD_W-1:0] r_shift;
   logic [BCNT_W-1:0]   r_bit_cnt;
   logic [P_WORD_W-1:0] r_sample;
   logic                r_valid;
   logic [P_ADDR_W-1:0] r_addr;
   logic                r_busy;
   logic                r_done;

   logic                w_rise_tick;
   logic                w_fall_tick_unused;
   logic [P_WORD_W-1:0] w_shift_next;

   audio_bit_clock_gen #(
      .DIV_HALF (P_CLK_DIV_HALF)
   ) u_bit_clock_gen (
      .i_clk       (Clock_100MHz),
      .i_clr_n     (Clear_n),
      .o_bit_clk   (BIT_CLK),
      .o_rise_tick (w_rise_tick),
      .o_fall_tick (w_fall_tick_unused)
   );

   assign w_shift_next = {r_shift[P_WORD_W-2:0], AUD_DATA_IN};

   // Capture sequencer with registered sample, strobe, address and status.
   always_ff @(posedge Clock_100MHz) begin
      if (!Clear_n) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= BCNT_TOP;
         r_sample  <= '0;
         r_valid   <= 1'b0;
         r_addr    <= ADDR_FRST;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (Start && !Abort) begin
                  r_state   <= ST_ARM;
                  r_addr    <= ADDR_FRST;
                  r_done    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= BCNT_TOP;
               end
            end
            ST_ARM: begin
               if (Abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_rise_tick) begin
                  // The tick that leaves ARM already carries the MSB.
                  r_state   <= ST_CAPTURE;
                  r_shift   <= w_shift_next;
                  r_bit_cnt <= r_bit_cnt - 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (Abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_valid) begin
                     if (r_addr == ADDR_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                     end else begin
                        r_addr <= r_addr + 1'b1;
                     end
                  end
                  if (w_rise_tick) begin
                     r_shift <= w_shift_next;
                     if (r_bit_cnt == '0) begin
                        r_bit_cnt <= BCNT_TOP;
                        r_sample  <= w_shift_next;
                        r_valid   <= 1'b1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                     end
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign Sample_Data  = r_sample;
   assign Sample_Valid = r_valid;
   assign Wr_En        = r_valid;
   assign Wr_Addr      = r_addr;
   assign Wr_Data      = r_sample;
   assign Busy         = r_busy;
   assign Done         = r_done;

endmodule

// File: tb/tb_audio_serial_capture.sv
// Directed bench for audio_serial_capture with a write scoreboard.
module tb_audio_serial_capture;

   logic        clk = 1'b0;
   logic        Clear_n = 1'b0;
   logic        Start = 1'b0;
   logic        Abort = 1'b0;
   logic        AUD_DATA_IN = 1'b0;
   logic        BIT_CLK;
   logic [15:0] Sample_Data;
   logic        Sample_Valid;
   logic        Wr_En;
   logic [17:0] Wr_Addr;
   logic [15:0] Wr_Data;
   logic        Busy;
   logic        Done;

   always #5 clk = ~clk;

   audio_serial_capture #(.DEPTH(4)) dut (
      .Clock_100MHz (clk),
      .Clear_n      (Clear_n),
      .Start        (Start),
      .Abort        (Abort),
      .AUD_DATA_IN  (AUD_DATA_IN),
      .BIT_CLK      (BIT_CLK),
      .Sample_Data  (Sample_Data),
      .Sample_Valid (Sample_Valid),
      .Wr_En        (Wr_En),
      .Wr_Addr      (Wr_Addr),
      .Wr_Data      (Wr_Data),
      .Busy         (Busy),
      .Done         (Done)
   );

   typedef struct {
      logic [17:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [17:0] exp_addr = 18'd1;
   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          last_wr_cyc = -1;
   int          cap_start_cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every Wr_En must match the head of the scoreboard.
   always @(negedge clk) begin
      if (Wr_En === 1'b1) begin
         wr_t e;
         check("unexpected_write", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(Wr_Addr), 32'(e.addr));
            check("wr_data", 32'(Wr_Data), 32'(e.data));
            check("sample_data", 32'(Sample_Data), 32'(e.data));
            check("sample_valid", 32'(Sample_Valid), 32'd1);
         end
         if (last_wr_cyc >= 0)
            check("wr_gap", 32'(cyc - last_wr_cyc), 32'd2272);
         else
            check("first_wr_latency_ok", 32'((cyc - cap_start_cyc) <= 2273), 32'd1);
         last_wr_cyc = cyc;
      end
   end

   task automatic wait_bclk_fall();
      logic prev;
      prev = BIT_CLK;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (prev === 1'b1 && BIT_CLK === 1'b0) return;
         prev = BIT_CLK;
      end
      check("bclk_fall_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] w, input int n, input int start_at);
      for (int i = 0; i < n; i++) begin
         AUD_DATA_IN = w[15-i];
         if (i == start_at) pulse_start();
         wait_bclk_fall();
      end
   endtask

   task automatic send_word(input logic [15:0] w, input int start_at);
      wr_t e;
      e.addr = exp_addr;
      e.data = w;
      exp_q.push_back(e);
      exp_addr = exp_addr + 18'd1;
      send_bits(w, 16, start_at);
   endtask

   // Align Start just after a BIT_CLK fall with the MSB already on the line.
   task automatic begin_capture(input logic [15:0] w0);
      wait_bclk_fall();
      AUD_DATA_IN = w0[15];
      exp_addr = 18'd1;
      last_wr_cyc = -1;
      cap_start_cyc = cyc;
      pulse_start();
   endtask

   initial begin
      int n;
      logic prev;

      // reset
      repeat (5) @(negedge clk);
      check("rst_bit_clk", 32'(BIT_CLK), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_wr_en", 32'(Wr_En), 32'd0);
      check("rst_wr_addr", 32'(Wr_Addr), 32'd1);
      check("rst_sample_data", 32'(Sample_Data), 32'd0);
      Clear_n = 1'b1;

      // divider half period
      wait_bclk_fall();
      for (int k = 0; k < 12; k++) begin
         prev = BIT_CLK;
         n = 0;
         while (BIT_CLK === prev && n < 200) begin
            @(negedge clk);
            n++;
         end
         check("bclk_half_period", 32'(n), 32'd71);
      end

      // capture two words, then fill to DEPTH=4
      begin_capture(16'hA5C3);
      check("busy_after_start", 32'(Busy), 32'd1);
      send_word(16'hA5C3, -1);
      send_word(16'h1234, -1);
      check("after_two_q_empty", 32'(exp_q.size()), 32'd0);
      send_word(16'h0F0F, -1);
      send_word(16'h8001, -1);
      repeat (3) @(negedge clk);
      check("end_q_empty", 32'(exp_q.size()), 32'd0);
      check("end_done", 32'(Done), 32'd1);
      check("end_busy", 32'(Busy), 32'd0);
      check("end_wr_addr", 32'(Wr_Addr), 32'd4);
      send_bits(16'hBEEF, 16, -1);
      check("done_held", 32'(Done), 32'd1);
      check("done_sample_hold", 32'(Sample_Data), 32'h8001);

      // abort after 7 bits, then recapture
      begin_capture(16'h7E81);
      check("restart_done_clr", 32'(Done), 32'd0);
      send_bits(16'h7E81, 7, -1);
      Abort = 1'b1;
      @(negedge clk);
      Abort = 1'b0;
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      repeat (3000) @(negedge clk);
      begin_capture(16'hFFFF);
      send_word(16'hFFFF, -1);

      // Start mid-capture must not realign the word
      send_word(16'h5A5A, 6);
      check("midstart_q_empty", 32'(exp_q.size()), 32'd0);

      // Clear_n pulse mid-word
      send_bits(16'h1357, 5, -1);
      Clear_n = 1'b0;
      @(negedge clk);
      Clear_n = 1'b1;
      check("clr_wr_addr", 32'(Wr_Addr), 32'd1);
      check("clr_busy", 32'(Busy), 32'd0);
      check("clr_sample_data", 32'(Sample_Data), 32'd0);
      repeat (3000) @(negedge clk);

      // Start and Abort together in IDLE
      Start = 1'b1;
      Abort = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      Abort = 1'b0;
      check("start_abort_busy", 32'(Busy), 32'd0);
      repeat (300) @(negedge clk);
      check("start_abort_busy_later", 32'(Busy), 32'd0);
      check("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

endmodule
